cam_line_capture: RTL and testbench

Producer side of the camera line interface. It takes the inward-camera pixel stream after `frame_capture_start`, assembles each image line in one of two ping-pong line banks, and presents completed lines to the pupil-detection consumer. The consumer reads a presented line through a random-access read port and frees it with a release handshake. Lines that arrive while both banks are occupied are discarded whole and flagged.

---
 rtl/cam_capture_pkg.sv | 28 ++
 rtl/line_bank_ram.sv | 37 +++
 rtl/cam_line_capture.sv | 174 +++++++++++++++++
 tb/tb_cam_line_capture.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_pkg.sv
// Shared types and default geometry for the camera line capture path.
// Index widths are derived here so every block sizes its counters the same way.
package cam_capture_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_LINE_PIXELS = 112;
    localparam int DEF_NUM_LINES   = 112;
    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_PIX_IDX_W   = idx_width(DEF_LINE_PIXELS);
    localparam int DEF_LINE_IDX_W  = idx_width(DEF_NUM_LINES);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } cap_state_t;

    typedef enum logic [1:0] {
        FREE,
        FILLING,
        FULL,
        PRESENTED
    } bank_state_t;

endpackage

// File: rtl/line_bank_ram.sv
// Two ping-pong line banks with one write port and one registered read port.
// The read register resets to zero; the storage array itself is never cleared.
module line_bank_ram
    import cam_capture_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    localparam int ADDR_W     = idx_width(LINE_PIXELS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_bank,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [PIXEL_WIDTH-1:0] wr_data,
    input  logic                   rd_bank,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [PIXEL_WIDTH-1:0] rd_data
);

    logic [PIXEL_WIDTH-1:0] mem [0:1][0:LINE_PIXELS-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/cam_line_capture.sv
// Camera line producer: assembles pixel lines into two ping-pong banks and
// presents completed lines in order to the consumer, discarding lines on overrun.
module cam_line_capture
    import cam_capture_pkg::*;
#(
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    localparam int PIX_W      = idx_width(LINE_PIXELS),
    localparam int LINE_W     = idx_width(NUM_LINES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_capture_start,
    input  logic                   pix_valid,
    input  logic [PIXEL_WIDTH-1:0] pix_data,
    input  logic [PIX_W-1:0]       line_rd_addr,
    output logic [PIXEL_WIDTH-1:0] line_rd_data,
    input  logic                   line_release,
    output logic                   line_valid,
    output logic [LINE_W-1:0]      line_number,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   overrun
);

    cap_state_t        state, state_nxt;
    bank_state_t       bank_state [2];
    logic [LINE_W-1:0] bank_line  [2];
    logic [PIX_W-1:0]  pix_count;
    logic [LINE_W-1:0] line_count;
    logic              wr_bank;
    logic              discard;
    logic              pres_bank;

    logic pix_accept, line_start, line_end;
    logic cur_bank, cur_discard, complete;
    logic present_en, present_bank;
    logic [LINE_W-1:0] present_line;
    logic frame_done_nxt;

    // Bank choice is made on the first pixel of a line; a completing line can
    // be presented in the same cycle if nothing is being shown.
    always_comb begin
        pix_accept   = (state == CAPTURE) && pix_valid;
        line_start   = pix_accept && (pix_count == '0);
        line_end     = pix_accept && (pix_count == PIX_W'(LINE_PIXELS - 1));
        cur_bank     = wr_bank;
        cur_discard  = discard;
        present_en   = 1'b0;
        present_bank = 1'b0;
        present_line = line_count;
        if (line_start) begin
            if (bank_state[0] == FREE) begin
                cur_bank    = 1'b0;
                cur_discard = 1'b0;
            end else if (bank_state[1] == FREE) begin
                cur_bank    = 1'b1;
                cur_discard = 1'b0;
            end else begin
                cur_bank    = 1'b0;
                cur_discard = 1'b1;
            end
        end
        complete = line_end && !cur_discard;
        if (!line_valid) begin
            if (bank_state[0] == FULL) begin
                present_en   = 1'b1;
                present_bank = 1'b0;
                present_line = bank_line[0];
            end else if (bank_state[1] == FULL) begin
                present_en   = 1'b1;
                present_bank = 1'b1;
                present_line = bank_line[1];
            end else if (complete) begin
                present_en   = 1'b1;
                present_bank = cur_bank;
                present_line = line_count;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE:    if (frame_capture_start) state_nxt = CAPTURE;
            CAPTURE: if (line_end && (line_count == LINE_W'(NUM_LINES - 1))) state_nxt = DRAIN;
            DRAIN: begin
                if ((bank_state[0] == FREE) && (bank_state[1] == FREE)) begin
                    state_nxt      = IDLE;
                    frame_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            pix_count     <= '0;
            line_count    <= '0;
            wr_bank       <= 1'b0;
            discard       <= 1'b0;
            pres_bank     <= 1'b0;
            bank_state[0] <= FREE;
            bank_state[1] <= FREE;
            line_valid    <= 1'b0;
            line_number   <= '0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_done_nxt;
            if ((state == IDLE) && frame_capture_start) begin
                pix_count     <= '0;
                line_count    <= '0;
                overrun       <= 1'b0;
                bank_state[0] <= FREE;
                bank_state[1] <= FREE;
                line_valid    <= 1'b0;
            end else begin
                if (pix_accept) begin
                    pix_count <= line_end ? '0 : pix_count + 1'b1;
                    if (line_end) line_count <= line_count + 1'b1;
                    if (line_start) begin
                        wr_bank <= cur_bank;
                        discard <= cur_discard;
                        if (cur_discard) overrun <= 1'b1;
                    end
                end
                // Later assignments take precedence: fill, complete, present.
                for (int b = 0; b < 2; b++) begin
                    if (line_release && line_valid && (pres_bank == 1'(b))) bank_state[b] <= FREE;
                    if (line_start && !cur_discard && (cur_bank == 1'(b))) bank_state[b] <= FILLING;
                    if (complete && (cur_bank == 1'(b))) bank_state[b] <= FULL;
                    if (present_en && (present_bank == 1'(b))) bank_state[b] <= PRESENTED;
                end
                if (present_en) begin
                    line_valid  <= 1'b1;
                    line_number <= present_line;
                    pres_bank   <= present_bank;
                end else if (line_release && line_valid) begin
                    line_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (line_start && !cur_discard) begin
            bank_line[cur_bank] <= line_count;
        end
    end

    assign frame_busy = (state != IDLE);

    line_bank_ram #(
        .LINE_PIXELS (LINE_PIXELS),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (pix_accept && !cur_discard),
        .wr_bank (cur_bank),
        .wr_addr (pix_count),
        .wr_data (pix_data),
        .rd_bank (pres_bank),
        .rd_addr (line_rd_addr),
        .rd_data (line_rd_data)
    );

endmodule

// File: tb/tb_cam_line_capture.sv
// Bench for cam_line_capture: scoreboard of presented line numbers plus
// table-driven read-back of line contents and hand-written corner sequences.
module tb_cam_line_capture;

    localparam int LP = 112;
    localparam int NL = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_capture_start = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic [6:0] line_rd_addr = '0;
    logic [7:0] line_rd_data;
    logic       line_release = 1'b0;
    logic       line_valid;
    logic [1:0] line_number;
    logic       frame_busy;
    logic       frame_done;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int exp_q [$];
    int exp_line;
    logic lv_prev = 1'b0;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    cam_line_capture #(
        .LINE_PIXELS (LP),
        .NUM_LINES   (NL),
        .PIXEL_WIDTH (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .frame_capture_start (frame_capture_start),
        .pix_valid           (pix_valid),
        .pix_data            (pix_data),
        .line_rd_addr        (line_rd_addr),
        .line_rd_data        (line_rd_data),
        .line_release        (line_release),
        .line_valid          (line_valid),
        .line_number         (line_number),
        .frame_busy          (frame_busy),
        .frame_done          (frame_done),
        .overrun             (overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pix_val(input int line, input int idx);
        return 8'((line * 37 + idx) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Each rising line_valid must present the oldest stored line.
    always @(negedge clock) begin
        if (line_valid && !lv_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL line_present: unexpected line %0d presented", line_number);
            end else begin
                exp_line = exp_q.pop_front();
                chk("line_order", 32'(line_number), 32'(exp_line));
            end
        end
        lv_prev <= line_valid;
    end

    task automatic do_reset();
        reset = 1'b1;
        pix_valid = 1'b0;
        line_release = 1'b0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_frame();
        frame_capture_start = 1'b1;
        tick();
        frame_capture_start = 1'b0;
        chk("busy_after_start", 32'(frame_busy), 1);
    endtask

    task automatic send_line(input int line, input bit stored, input bit rel_at_last);
        for (int i = 0; i < LP; i++) begin
            pix_valid = 1'b1;
            pix_data  = pix_val(line, i);
            if (i == LP - 1) begin
                if (stored) exp_q.push_back(line);
                if (rel_at_last) line_release = 1'b1;
            end
            tick();
        end
        line_release = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n = 0;
        while (!line_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_line_valid", 32'(line_valid), 1);
    endtask

    task automatic release_line();
        line_release = 1'b1;
        tick();
        line_release = 1'b0;
        chk("release_drops_valid", 32'(line_valid), 0);
    endtask

    task automatic check_reads(input int line);
        rd_vec_t vec [6];
        int addrs [6] = '{0, 1, 37, 55, 110, 111};
        for (int i = 0; i < 6; i++) begin
            vec[i].addr = 7'(addrs[i]);
            vec[i].exp  = pix_val(line, addrs[i]);
        end
        for (int i = 0; i < 6; i++) begin
            line_rd_addr = vec[i].addr;
            tick();
            chk($sformatf("read_l%0d_a%0d", line, vec[i].addr), 32'(line_rd_data), 32'(vec[i].exp));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_line_valid", 32'(line_valid), 0);
        chk("rst_line_number", 32'(line_number), 0);
        chk("rst_rd_data", 32'(line_rd_data), 0);
        chk("rst_busy", 32'(frame_busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;

        // Single line, immediate release
        do_reset();
        start_frame();
        send_line(0, 1'b1, 1'b0);
        pix_valid = 1'b0;
        chk("single_valid", 32'(line_valid), 1);
        chk("single_number", 32'(line_number), 0);
        check_reads(0);
        release_line();

        // Back-to-back lines, slow consumer
        do_reset();
        start_frame();
        fork
            begin
                send_line(0, 1'b1, 1'b0);
                send_line(1, 1'b1, 1'b0);
                pix_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_valid(600);
                    repeat (50) tick();
                    release_line();
                end
            end
        join
        chk("b2b_overrun", 32'(overrun), 0);

        // Overrun: third line discarded, index skipped
        do_reset();
        start_frame();
        send_line(0, 1'b1, 1'b0);
        send_line(1, 1'b1, 1'b0);
        send_line(2, 1'b0, 1'b0);
        pix_valid = 1'b0;
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_valid", 32'(line_valid), 1);
        chk("ovr_number0", 32'(line_number), 0);
        release_line();
        tick();
        chk("ovr_next_valid", 32'(line_valid), 1);
        chk("ovr_number1", 32'(line_number), 1);
        check_reads(1);
        release_line();
        send_line(3, 1'b1, 1'b0);
        pix_valid = 1'b0;
        chk("ovr_valid3", 32'(line_valid), 1);
        chk("ovr_number3", 32'(line_number), 3);
        check_reads(3);
        release_line();
        chk("ovr_done_not_yet", 32'(frame_done), 0);
        tick();
        chk("ovr_done", 32'(frame_done), 1);
        chk("ovr_busy_low", 32'(frame_busy), 0);

        // Frame completion with prompt releases, then restart
        do_reset();
        start_frame();
        for (int l = 0; l < NL; l++) begin
            send_line(l, 1'b1, 1'b0);
            pix_valid = 1'b0;
            chk("frm_valid", 32'(line_valid), 1);
            chk("frm_busy", 32'(frame_busy), 1);
            release_line();
            chk("frm_no_early_done", 32'(frame_done), 0);
        end
        tick();
        chk("frm_done", 32'(frame_done), 1);
        chk("frm_busy_falls", 32'(frame_busy), 0);
        tick();
        chk("frm_done_pulse", 32'(frame_done), 0);
        start_frame();
        chk("frm_overrun_cleared", 32'(overrun), 0);
        send_line(0, 1'b1, 1'b0);
        pix_valid = 1'b0;
        chk("frm_restart_number", 32'(line_number), 0);
        check_reads(0);
        release_line();

        // Line 1 completes in the same cycle line 0 is released
        do_reset();
        start_frame();
        send_line(0, 1'b1, 1'b0);
        send_line(1, 1'b1, 1'b1);
        pix_valid = 1'b0;
        chk("sim_gap", 32'(line_valid), 0);
        tick();
        chk("sim_present", 32'(line_valid), 1);
        chk("sim_number", 32'(line_number), 1);
        check_reads(1);
        release_line();

        // Reset mid-frame
        do_reset();
        start_frame();
        for (int i = 0; i < 60; i++) begin
            pix_valid = 1'b1;
            pix_data  = pix_val(0, i);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(line_valid), 0);
        chk("mid_rst_number", 32'(line_number), 0);
        chk("mid_rst_rd_data", 32'(line_rd_data), 0);
        chk("mid_rst_busy", 32'(frame_busy), 0);
        chk("mid_rst_done", 32'(frame_done), 0);
        chk("mid_rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < LP; i++) begin
            pix_valid = 1'b1;
            pix_data  = pix_val(2, i);
            tick();
        end
        pix_valid = 1'b0;
        chk("idle_ignores_pix", 32'(line_valid), 0);
        chk("idle_not_busy", 32'(frame_busy), 0);
        start_frame();
        send_line(0, 1'b1, 1'b0);
        pix_valid = 1'b0;
        chk("post_rst_valid", 32'(line_valid), 1);
        chk("post_rst_number", 32'(line_number), 0);
        check_reads(0);
        release_line();

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
